// File: rtl/dmi_req_scheduler.sv
// dmi_req_scheduler: serialises DMI requests from the UART TAP onto the Debug
// Module port, bounding each access with a timeout and keeping the sticky dmistat.
module dmi_req_scheduler #(
    parameter int ABITS   = 7,
    parameter int WIDTH   = ABITS + 34,
    parameter int TIMEOUT = 1024
) (
    input  logic             CLK_I,
    input  logic             RST_NI,
    input  logic [WIDTH-1:0] WRITE_DATA_I,
    input  logic             WRITE_VALID_I,
    output logic             WRITE_READY_O,
    output logic [WIDTH-1:0] READ_DATA_O,
    output logic             READ_VALID_O,
    input  logic             READ_READY_I,
    input  logic             DMI_RESET_I,
    input  logic             DMI_HARD_RESET_I,
    output logic [1:0]       DMI_ERROR_O,
    output logic [ABITS-1:0] DMI_REQ_ADDR_O,
    output logic [31:0]      DMI_REQ_DATA_O,
    output logic [1:0]       DMI_REQ_OP_O,
    output logic             DMI_REQ_VALID_O,
    input  logic             DMI_REQ_READY_I,
    input  logic [31:0]      DMI_RESP_DATA_I,
    input  logic [1:0]       DMI_RESP_RESP_I,
    input  logic             DMI_RESP_VALID_I,
    output logic             DMI_RESP_READY_O
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_RESP, RESULT} state_t;

    state_t           state_q, state_d;
    logic [ABITS-1:0] addr_q, addr_d;
    logic [31:0]      data_q, data_d;
    logic [1:0]       op_q, op_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [1:0]       status_q, status_d;
    logic [1:0]       err_q, err_d;
    logic             drop_q, drop_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic req_fire, resp_fire, timed_out, accept, is_nop;

    assign WRITE_READY_O    = (state_q == IDLE);
    assign READ_VALID_O     = (state_q == RESULT);
    assign READ_DATA_O      = {addr_q, rdata_q, status_q};
    assign DMI_ERROR_O      = err_q;
    assign DMI_REQ_ADDR_O   = addr_q;
    assign DMI_REQ_DATA_O   = data_q;
    assign DMI_REQ_OP_O     = op_q;
    assign DMI_REQ_VALID_O  = (state_q == REQ) && !drop_q;
    assign DMI_RESP_READY_O = (state_q == WAIT_RESP) || drop_q;

    assign req_fire  = DMI_REQ_VALID_O && DMI_REQ_READY_I;
    assign resp_fire = (state_q == WAIT_RESP) && !drop_q && DMI_RESP_VALID_I;
    assign timed_out = ((state_q == REQ) || (state_q == WAIT_RESP)) && (cnt_q == CNT_MAX) && !resp_fire;
    assign accept    = WRITE_VALID_I && !DMI_HARD_RESET_I;
    assign is_nop    = (WRITE_DATA_I[1:0] == 2'd0) || (WRITE_DATA_I[1:0] == 2'd3);

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        data_d   = data_q;
        op_d     = op_q;
        rdata_d  = rdata_q;
        status_d = status_q;
        cnt_d    = cnt_q;
        err_d    = DMI_RESET_I ? 2'd0 : err_q;
        // any response seen while dropping belongs to an abandoned access
        drop_d   = drop_q && !DMI_RESP_VALID_I;

        case (state_q)
            IDLE: if (accept) begin
                addr_d   = WRITE_DATA_I[WIDTH-1:34];
                data_d   = WRITE_DATA_I[33:2];
                op_d     = WRITE_DATA_I[1:0];
                rdata_d  = WRITE_DATA_I[33:2];
                status_d = err_q;
                if (is_nop || (err_q != 2'd0)) begin
                    state_d = RESULT;
                end else begin
                    state_d = REQ;
                    cnt_d   = '0;
                end
            end
            REQ: begin
                cnt_d = cnt_q + 1'b1;
                if (req_fire) state_d = WAIT_RESP;
            end
            WAIT_RESP: begin
                cnt_d = cnt_q + 1'b1;
                if (resp_fire) begin
                    if (op_q == 2'd1) rdata_d = DMI_RESP_DATA_I;
                    status_d = DMI_RESP_RESP_I;
                    if (DMI_RESP_RESP_I != 2'd0) err_d = DMI_RESP_RESP_I;
                    state_d = RESULT;
                end
            end
            RESULT: if (READ_READY_I) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // a request handed to the DM in the abort cycle still owes a response
        if (timed_out) begin
            status_d = 2'd3;
            err_d    = 2'd3;
            state_d  = RESULT;
            if ((state_q == WAIT_RESP) || req_fire) drop_d = 1'b1;
        end

        if (DMI_HARD_RESET_I) begin
            state_d = IDLE;
            err_d   = 2'd0;
            cnt_d   = '0;
            if (((state_q == WAIT_RESP) && !resp_fire) || req_fire) drop_d = 1'b1;
        end
    end

    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            data_q   <= '0;
            op_q     <= '0;
            rdata_q  <= '0;
            status_q <= '0;
            err_q    <= '0;
            drop_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            op_q     <= op_d;
            rdata_q  <= rdata_d;
            status_q <= status_d;
            err_q    <= err_d;
            drop_q   <= drop_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_dmi_req_scheduler.sv
// Directed bench for dmi_req_scheduler: a transaction-level model is checked
// against the DUT every cycle, alongside hand-computed expectations.
module tb_dmi_req_scheduler;

    localparam int ABITS   = 7;
    localparam int WIDTH   = ABITS + 34;
    localparam int TIMEOUT = 16;

    logic             CLK_I = 1'b0;
    logic             RST_NI;
    logic [WIDTH-1:0] WRITE_DATA_I;
    logic             WRITE_VALID_I;
    logic             WRITE_READY_O;
    logic [WIDTH-1:0] READ_DATA_O;
    logic             READ_VALID_O;
    logic             READ_READY_I;
    logic             DMI_RESET_I;
    logic             DMI_HARD_RESET_I;
    logic [1:0]       DMI_ERROR_O;
    logic [ABITS-1:0] DMI_REQ_ADDR_O;
    logic [31:0]      DMI_REQ_DATA_O;
    logic [1:0]       DMI_REQ_OP_O;
    logic             DMI_REQ_VALID_O;
    logic             DMI_REQ_READY_I;
    logic [31:0]      DMI_RESP_DATA_I;
    logic [1:0]       DMI_RESP_RESP_I;
    logic             DMI_RESP_VALID_I;
    logic             DMI_RESP_READY_O;

    dmi_req_scheduler #(.ABITS(ABITS), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .CLK_I(CLK_I), .RST_NI(RST_NI),
        .WRITE_DATA_I(WRITE_DATA_I), .WRITE_VALID_I(WRITE_VALID_I), .WRITE_READY_O(WRITE_READY_O),
        .READ_DATA_O(READ_DATA_O), .READ_VALID_O(READ_VALID_O), .READ_READY_I(READ_READY_I),
        .DMI_RESET_I(DMI_RESET_I), .DMI_HARD_RESET_I(DMI_HARD_RESET_I), .DMI_ERROR_O(DMI_ERROR_O),
        .DMI_REQ_ADDR_O(DMI_REQ_ADDR_O), .DMI_REQ_DATA_O(DMI_REQ_DATA_O), .DMI_REQ_OP_O(DMI_REQ_OP_O),
        .DMI_REQ_VALID_O(DMI_REQ_VALID_O), .DMI_REQ_READY_I(DMI_REQ_READY_I),
        .DMI_RESP_DATA_I(DMI_RESP_DATA_I), .DMI_RESP_RESP_I(DMI_RESP_RESP_I),
        .DMI_RESP_VALID_I(DMI_RESP_VALID_I), .DMI_RESP_READY_O(DMI_RESP_READY_O)
    );

    always #5 CLK_I = ~CLK_I;

    int vectors = 0;
    int miscompares = 0;

    task automatic chkb(input string nm, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0b expected %0b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk2(input string nm, input logic [1:0] act, input logic [1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chkw(input string nm, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] mk(input logic [ABITS-1:0] a, input logic [31:0] d,
                                            input logic [1:0] o);
        return {a, d, o};
    endfunction

    // Transaction-level model: one access in flight, described by phase
    // (idle / talking to the DM / holding a result) plus what has happened so far.
    typedef enum {M_IDLE, M_DM, M_RES} mph_t;
    mph_t             m_ph     = M_IDLE;
    bit               m_issued = 1'b0;
    bit               m_drop   = 1'b0;
    int               m_age    = 0;
    logic [1:0]       m_err    = 2'd0;
    logic [WIDTH-1:0] m_req    = '0;
    logic [WIDTH-1:0] m_res    = '0;

    always @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            m_ph <= M_IDLE; m_issued <= 1'b0; m_drop <= 1'b0; m_age <= 0;
            m_err <= 2'd0; m_req <= '0; m_res <= '0;
        end else if (DMI_HARD_RESET_I) begin
            m_ph <= M_IDLE; m_err <= 2'd0; m_age <= 0;
            if (m_ph == M_DM && (m_issued ? !DMI_RESP_VALID_I : (!m_drop && DMI_REQ_READY_I)))
                m_drop <= 1'b1;
            else if (m_drop && DMI_RESP_VALID_I)
                m_drop <= 1'b0;
        end else begin
            if (m_drop && DMI_RESP_VALID_I) m_drop <= 1'b0;
            if (DMI_RESET_I) m_err <= 2'd0;
            case (m_ph)
                M_IDLE: if (WRITE_VALID_I) begin
                    m_req <= WRITE_DATA_I;
                    if (WRITE_DATA_I[1:0] == 2'd0 || WRITE_DATA_I[1:0] == 2'd3 || m_err != 2'd0) begin
                        m_ph  <= M_RES;
                        m_res <= {WRITE_DATA_I[WIDTH-1:2], m_err};
                    end else begin
                        m_ph <= M_DM; m_issued <= 1'b0; m_age <= 0;
                    end
                end
                M_DM: begin
                    if (m_issued && DMI_RESP_VALID_I) begin
                        m_res <= {m_req[WIDTH-1:34],
                                  (m_req[1:0] == 2'd1) ? DMI_RESP_DATA_I : m_req[33:2],
                                  DMI_RESP_RESP_I};
                        if (DMI_RESP_RESP_I != 2'd0) m_err <= DMI_RESP_RESP_I;
                        m_ph <= M_RES;
                    end else if (m_age == TIMEOUT - 1) begin
                        m_res <= {m_req[WIDTH-1:2], 2'd3};
                        m_err <= 2'd3;
                        m_ph  <= M_RES;
                        if (m_issued || (!m_drop && DMI_REQ_READY_I)) m_drop <= 1'b1;
                    end else begin
                        m_age <= m_age + 1;
                        if (!m_issued && !m_drop && DMI_REQ_READY_I) m_issued <= 1'b1;
                    end
                end
                M_RES: if (READ_READY_I) m_ph <= M_IDLE;
                default: m_ph <= M_IDLE;
            endcase
        end
    end

    always @(negedge CLK_I) begin
        if (RST_NI === 1'b1) begin
            chkb("m_write_ready", WRITE_READY_O, m_ph == M_IDLE);
            chkb("m_req_valid", DMI_REQ_VALID_O, m_ph == M_DM && !m_issued && !m_drop);
            if (m_ph == M_DM && !m_issued && !m_drop)
                chkw("m_req_fields", {DMI_REQ_ADDR_O, DMI_REQ_DATA_O, DMI_REQ_OP_O}, m_req);
            chkb("m_resp_ready", DMI_RESP_READY_O, (m_ph == M_DM && m_issued) || m_drop);
            chkb("m_read_valid", READ_VALID_O, m_ph == M_RES);
            if (m_ph == M_RES) chkw("m_read_data", READ_DATA_O, m_res);
            chk2("m_error", DMI_ERROR_O, m_err);
        end
    end

    task automatic step();
        @(posedge CLK_I);
        #1;
    endtask

    task automatic send(input logic [WIDTH-1:0] w);
        chkb("send_ready", WRITE_READY_O, 1'b1);
        WRITE_DATA_I  = w;
        WRITE_VALID_I = 1'b1;
        step();
        WRITE_VALID_I = 1'b0;
    endtask

    task automatic respond(input logic [31:0] d, input logic [1:0] r);
        DMI_RESP_DATA_I  = d;
        DMI_RESP_RESP_I  = r;
        DMI_RESP_VALID_I = 1'b1;
        step();
        DMI_RESP_VALID_I = 1'b0;
    endtask

    task automatic take();
        READ_READY_I = 1'b1;
        step();
        READ_READY_I = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        RST_NI = 1'b0; WRITE_DATA_I = '0; WRITE_VALID_I = 1'b0; READ_READY_I = 1'b0;
        DMI_RESET_I = 1'b0; DMI_HARD_RESET_I = 1'b0; DMI_REQ_READY_I = 1'b1;
        DMI_RESP_DATA_I = '0; DMI_RESP_RESP_I = '0; DMI_RESP_VALID_I = 1'b0;
        repeat (3) step();
        chkb("rst_write_ready", WRITE_READY_O, 1'b1);
        chkb("rst_read_valid", READ_VALID_O, 1'b0);
        chkw("rst_read_data", READ_DATA_O, '0);
        chk2("rst_error", DMI_ERROR_O, 2'd0);
        chkb("rst_req_valid", DMI_REQ_VALID_O, 1'b0);
        RST_NI = 1'b1;
        step();

        // plain read, response three cycles after issue
        send(mk(7'h11, 32'h0, 2'd1));
        chkb("t1_req_valid", DMI_REQ_VALID_O, 1'b1);
        chk2("t1_req_op", DMI_REQ_OP_O, 2'd1);
        step();
        step();
        step();
        respond(32'hDEADBEEF, 2'd0);
        chkb("t1_read_valid", READ_VALID_O, 1'b1);
        chkw("t1_read_data", READ_DATA_O, mk(7'h11, 32'hDEADBEEF, 2'd0));
        take();
        chk2("t1_error", DMI_ERROR_O, 2'd0);

        // failed write, with a dmireset in the same cycle that must lose
        send(mk(7'h10, 32'h1, 2'd2));
        step();
        DMI_RESET_I = 1'b1;
        respond(32'hFFFF_0000, 2'd2);
        DMI_RESET_I = 1'b0;
        chkw("t2_read_data", READ_DATA_O, mk(7'h10, 32'h1, 2'd2));
        chk2("t2_error", DMI_ERROR_O, 2'd2);
        take();
        send(mk(7'h04, 32'h0, 2'd1));
        chkb("t2_blocked_req", DMI_REQ_VALID_O, 1'b0);
        chkb("t2_blocked_valid", READ_VALID_O, 1'b1);
        chkw("t2_blocked_data", READ_DATA_O, mk(7'h04, 32'h0, 2'd2));
        take();
        DMI_RESET_I = 1'b1;
        step();
        DMI_RESET_I = 1'b0;
        chk2("t2_cleared", DMI_ERROR_O, 2'd0);
        send(mk(7'h04, 32'h0, 2'd1));
        chkb("t2_reissued", DMI_REQ_VALID_O, 1'b1);
        step();
        respond(32'h12345678, 2'd0);
        chkw("t2_read_data2", READ_DATA_O, mk(7'h04, 32'h12345678, 2'd0));
        take();

        // DM accepts but never answers
        send(mk(7'h20, 32'h0, 2'd1));
        n = 0;
        while (!READ_VALID_O && n < 40) begin
            step();
            n++;
        end
        chki("t3_timeout_lat", n, TIMEOUT);
        chkw("t3_read_data", READ_DATA_O, mk(7'h20, 32'h0, 2'd3));
        chk2("t3_error", DMI_ERROR_O, 2'd3);
        chkb("t3_resp_ready", DMI_RESP_READY_O, 1'b1);
        take();
        respond(32'hBAD0BAD0, 2'd0);
        chkb("t3_late_consumed", DMI_RESP_READY_O, 1'b0);
        step();
        step();
        chkb("t3_no_result", READ_VALID_O, 1'b0);

        // hard reset in IDLE clears the error and drops a coincident write
        DMI_HARD_RESET_I = 1'b1;
        WRITE_DATA_I = mk(7'h30, 32'h0, 2'd1);
        WRITE_VALID_I = 1'b1;
        step();
        DMI_HARD_RESET_I = 1'b0;
        WRITE_VALID_I = 1'b0;
        chk2("t4_hard_clear", DMI_ERROR_O, 2'd0);
        chkb("t4_dropped_write", WRITE_READY_O, 1'b1);
        chkb("t4_dropped_req", DMI_REQ_VALID_O, 1'b0);

        // nops answer next cycle and hold the result while the TAP stalls
        send(mk(7'h00, 32'hA5A5A5A5, 2'd0));
        chkb("t5_nop_valid", READ_VALID_O, 1'b1);
        chkb("t5_nop_req", DMI_REQ_VALID_O, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            chkw("t5_nop_hold", READ_DATA_O, mk(7'h00, 32'hA5A5A5A5, 2'd0));
        end
        take();
        send(mk(7'h33, 32'h5, 2'd3));
        chkw("t5_op3_data", READ_DATA_O, mk(7'h33, 32'h5, 2'd0));
        take();

        // hard reset while the DM stalls the request
        DMI_REQ_READY_I = 1'b0;
        send(mk(7'h15, 32'h7, 2'd2));
        chkb("t6_req_valid", DMI_REQ_VALID_O, 1'b1);
        step();
        DMI_HARD_RESET_I = 1'b1;
        step();
        DMI_HARD_RESET_I = 1'b0;
        chkb("t6_withdrawn", DMI_REQ_VALID_O, 1'b0);
        chkb("t6_idle", WRITE_READY_O, 1'b1);
        step();
        chkb("t6_no_result", READ_VALID_O, 1'b0);
        DMI_REQ_READY_I = 1'b1;

        // hard reset while waiting: the stray response must be swallowed first
        send(mk(7'h16, 32'h0, 2'd1));
        step();
        DMI_HARD_RESET_I = 1'b1;
        step();
        DMI_HARD_RESET_I = 1'b0;
        chkb("t7_drop_ready", DMI_RESP_READY_O, 1'b1);
        send(mk(7'h17, 32'h0, 2'd1));
        chkb("t7_held_off", DMI_REQ_VALID_O, 1'b0);
        respond(32'h0BADF00D, 2'd0);
        chkb("t7_released", DMI_REQ_VALID_O, 1'b1);
        step();
        respond(32'h600DCAFE, 2'd0);
        chkw("t7_read_data", READ_DATA_O, mk(7'h17, 32'h600DCAFE, 2'd0));
        take();

        // async reset while waiting for the DM
        send(mk(7'h22, 32'h0, 2'd1));
        step();
        #2 RST_NI = 1'b0;
        #1;
        chkb("t8_rst_read_valid", READ_VALID_O, 1'b0);
        chkb("t8_rst_req_valid", DMI_REQ_VALID_O, 1'b0);
        chkb("t8_rst_resp_ready", DMI_RESP_READY_O, 1'b0);
        chkw("t8_rst_read_data", READ_DATA_O, '0);
        chk2("t8_rst_error", DMI_ERROR_O, 2'd0);
        chkb("t8_rst_write_ready", WRITE_READY_O, 1'b1);
        step();
        RST_NI = 1'b1;
        step();
        send(mk(7'h22, 32'h0, 2'd1));
        step();
        respond(32'hCAFEF00D, 2'd0);
        chkw("t8_read_data", READ_DATA_O, mk(7'h22, 32'hCAFEF00D, 2'd0));
        take();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
